p2p_req_resp_link: RTL

- Request/response link controller that sits directly upstream of the responder node in the point-to-point interconnect.
- Buffers outgoing 4-bit request messages from the sender node in a small FIFO and issues them onto the link one at a time.
- Waits for the responder's reply, with a timeout, and returns the reply, or a timeout indication, to the sender through a valid/ready handshake.

---
 rtl/p2p_req_resp_link.sv | 117 +++++++++++
 1 files changed

// File: rtl/p2p_req_resp_link.sv
// p2p_req_resp_link: buffers sender requests in a small FIFO, issues them
// one at a time onto the point-to-point link, waits for the responder's
// reply (or a timeout) and hands the result back over a valid/ready port.
module p2p_req_resp_link #(
    parameter int MSG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    input  logic [MSG_W-1:0]                req_data,
    output logic                            req_ready,
    output logic                            link_out_valid,
    output logic [MSG_W-1:0]                link_out_data,
    input  logic                            link_in_valid,
    input  logic [MSG_W-1:0]                link_in_data,
    output logic                            rsp_valid,
    output logic [MSG_W-1:0]                rsp_data,
    output logic                            rsp_timeout,
    input  logic                            rsp_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            stray_rsp
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    logic [MSG_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [TW-1:0]    timer;
    logic             push, pop;

    // No bypass: a full FIFO refuses even on the edge it pops.
    assign req_ready  = (count != CW'(FIFO_DEPTH));
    assign push       = req_valid && req_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign fifo_count = count;

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= req_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Transaction FSM: issue head request, wait for reply/timeout, hold response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            timer          <= '0;
            link_out_valid <= 1'b0;
            link_out_data  <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_timeout    <= 1'b0;
            stray_rsp      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (link_in_valid) stray_rsp <= 1'b1;
                    if (pop) begin
                        link_out_data  <= mem[rd_ptr];
                        link_out_valid <= 1'b1;
                        timer          <= '0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    link_out_valid <= 1'b0;
                    // A reply on the final timer cycle still counts as a reply.
                    if (link_in_valid) begin
                        rsp_data    <= link_in_data;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: begin
                    if (link_in_valid) stray_rsp <= 1'b1;
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
